// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - state type and helpers shared by the serial subtractor
`include "serial_sub_defs.vh"

package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `SERIAL_SUB_ST_IDLE,
        ST_RUN  = `SERIAL_SUB_ST_RUN,
        ST_DONE = `SERIAL_SUB_ST_DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_defs.vh
// rtl/serial_sub_defs.vh - shared state encodings and WIDTH legality check for serial_sub
`ifndef SERIAL_SUB_DEFS_VH
`define SERIAL_SUB_DEFS_VH

`define SERIAL_SUB_ST_IDLE 2'd0
`define SERIAL_SUB_ST_RUN  2'd1
`define SERIAL_SUB_ST_DONE 2'd2

// Elaboration-time guard: operands narrower than 2 or wider than 64 bits are not supported
`define SERIAL_SUB_CHECK_WIDTH(W) \
    if (((W) < 2) || ((W) > 64)) begin : g_bad_width \
        $error("serial_sub: WIDTH out of range 2..64"); \
    end

`endif

// File: rtl/serial_sub_fs.sv
// rtl/serial_sub_fs.sv - one-bit full subtractor cell
module serial_sub_fs (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    // Difference bit and borrow-out of a - b - bin
    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial unsigned subtractor with start/done handshake
`include "serial_sub_defs.vh"

module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    `SERIAL_SUB_CHECK_WIDTH(WIDTH)

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             w_d;
    logic             w_bout;
    logic             w_last;

    serial_sub_fs u_fs (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_bin),
        .o_diff (w_d),
        .o_bout (w_bout)
    );

    assign w_last = (r_cnt == CNT_LAST);

    // Next-state: accept start only in IDLE, run WIDTH steps, one DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operand capture, per-bit shift, borrow chain and result load on the last step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_bin <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_d   <= {w_d, r_d[WIDTH-1:1]};
                    r_bin <= w_bout;
                    if (w_last) begin
                        r_diff   <= {w_d, r_d[WIDTH-1:1]};
                        r_borrow <= w_bout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (r_state == ST_RUN);
    assign o_done   = (r_state == ST_DONE);
    assign o_diff   = r_diff;
    assign o_borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub at WIDTH=8
module tb_serial_sub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;

    int               n_total;
    int               n_bad;
    logic [WIDTH-1:0] prev_diff;
    logic             prev_borrow;

    serial_sub #(.WIDTH(WIDTH)) u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (i_start),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_diff   (o_diff),
        .o_borrow (o_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction; expected values come from a plain arithmetic model
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ed, input logic eb, input string tag);
        int   busy_n;
        logic stable;
        @(posedge clk); #1;
        i_start = 1'b1; i_a = a; i_b = b;
        @(posedge clk); #1;
        i_start = 1'b0; i_a = WIDTH'($urandom); i_b = WIDTH'($urandom);
        busy_n = 0;
        stable = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            if (o_busy && !o_done) busy_n++;
            if (o_diff !== prev_diff || o_borrow !== prev_borrow) stable = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(WIDTH));
        chk({tag, "_stable"}, {63'd0, stable}, 64'd1);
        chk({tag, "_done"}, {63'd0, o_done}, 64'd1);
        chk({tag, "_busy_in_done"}, {63'd0, o_busy}, 64'd0);
        chk({tag, "_diff"}, 64'(o_diff), 64'(ed));
        chk({tag, "_borrow"}, {63'd0, o_borrow}, {63'd0, eb});
        prev_diff = ed;
        prev_borrow = eb;
        @(negedge clk);
        chk({tag, "_done_1cyc"}, {63'd0, o_done}, 64'd0);
    endtask

    initial begin
        int               done_at[$];
        int               n_done;
        int               lat;
        logic             prev_done;
        logic             wide;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        n_total = 0;
        n_bad = 0;
        prev_diff = '0;
        prev_borrow = 1'b0;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_a = '0;
        i_b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_done", {63'd0, o_done}, 64'd0);
        chk("rst_diff", 64'(o_diff), 64'd0);
        chk("rst_borrow", {63'd0, o_borrow}, 64'd0);
        rst_n = 1'b1;

        // Directed vectors
        run_op(8'h35, 8'h12, 8'h23, 1'b0, "t1");
        run_op(8'h12, 8'h35, 8'hDD, 1'b1, "t2a");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, "t2b");
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "t2c");
        run_op(8'h00, 8'h00, 8'h00, 1'b0, "t2d");
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, "t2e");

        // Start pulsed again during RUN must be ignored
        @(posedge clk); #1;
        i_start = 1'b1; i_a = 8'h80; i_b = 8'h01;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_start = 1'b1; i_a = 8'h00; i_b = 8'h00;
        @(posedge clk); #1;
        i_start = 1'b0;
        lat = 0;
        while (!o_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t3_done_seen", {63'd0, o_done}, 64'd1);
        chk("t3_diff", 64'(o_diff), 64'h7F);
        chk("t3_borrow", {63'd0, o_borrow}, 64'd0);
        n_done = 0;
        wide = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (o_done) n_done++;
            if (o_busy) wide = 1'b1;
        end
        chk("t3_no_second_done", 64'(n_done), 64'd0);
        chk("t3_no_second_run", {63'd0, wide}, 64'd0);
        prev_diff = 8'h7F;
        prev_borrow = 1'b0;

        // Reset in the middle of RUN
        @(posedge clk); #1;
        i_start = 1'b1; i_a = 8'h33; i_b = 8'h11;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_busy_before", {63'd0, o_busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", {63'd0, o_busy}, 64'd0);
        chk("t4_rst_done", {63'd0, o_done}, 64'd0);
        chk("t4_rst_diff", 64'(o_diff), 64'd0);
        chk("t4_rst_borrow", {63'd0, o_borrow}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        prev_diff = '0;
        prev_borrow = 1'b0;
        run_op(8'h10, 8'h0F, 8'h01, 1'b0, "t4");

        // Start held high: one acceptance every WIDTH+2 cycles, single-cycle done
        @(posedge clk); #1;
        i_start = 1'b1; i_a = 8'h05; i_b = 8'h03;
        prev_done = 1'b0;
        wide = 1'b0;
        n_done = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (o_done) begin
                done_at.push_back(c);
                if (o_diff !== 8'h02) n_done++;
            end
            if (o_done && prev_done) wide = 1'b1;
            if (o_done && o_busy) wide = 1'b1;
            prev_done = o_done;
        end
        i_start = 1'b0;
        chk("t5_done_count", 64'(done_at.size()), 64'd4);
        chk("t5_single_cycle", {63'd0, wide}, 64'd0);
        chk("t5_diff_bad_count", 64'(n_done), 64'd0);
        for (int i = 1; i < done_at.size(); i++)
            chk("t5_interval", 64'(done_at[i] - done_at[i-1]), 64'(WIDTH + 2));
        repeat (WIDTH + 3) @(negedge clk);
        chk("t5_idle", {63'd0, o_busy}, 64'd0);
        prev_diff = 8'h02;
        prev_borrow = 1'b0;

        // Random operands against the arithmetic model
        for (int r = 0; r < 1000; r++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_op(ra, rb, ra - rb, (ra < rb), "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
